// File: rtl/ekf_pkg.sv
// rtl/ekf_pkg.sv - shared types, sensor ids and default timing for the EKF update scheduler
package ekf_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEAS,
      S_CAPT,
      S_FUSE,
      S_DONE
   } state_t;

   localparam logic SRC_RAD = 1'b0;
   localparam logic SRC_IR  = 1'b1;

   localparam int DEF_MU_LAT  = 2;
   localparam int DEF_FUS_LAT = 3;
   localparam int DEF_TIMEOUT = 255;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ekf_rr_arb.sv
// rtl/ekf_rr_arb.sv - 2-way round-robin arbiter; index 0 radar, 1 IR; pointer holds last grant
module ekf_rr_arb
   import ekf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] elig,
   input  logic       en,
   output logic       gnt_valid,
   output logic       gnt_id
);

   logic       ptr;
   logic [1:0] cand;

   assign cand      = req & elig & {2{en}};
   assign gnt_valid = |cand;
   // on contention the sensor not granted last time wins
   assign gnt_id    = (&cand) ? ~ptr : cand[1];

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= SRC_IR;
      else if (gnt_valid)
         ptr <= gnt_id;
   end

endmodule

// File: rtl/ekf_sched.sv
// rtl/ekf_sched.sv - radar/IR EKF update scheduler over one shared measurement unit; single-sensor timeout under EKF_SCHED_TIMEOUT_EN
module ekf_sched
   import ekf_pkg::*;
#(
   parameter int MU_LAT  = DEF_MU_LAT,
   parameter int FUS_LAT = DEF_FUS_LAT,
   parameter int TIMEOUT = DEF_TIMEOUT
)
(
   input  logic clk,
   input  logic rst,
   input  logic rad_req,
   input  logic ir_req,
   output logic rad_ack,
   output logic ir_ack,
   output logic mu_en,
   output logic mu_sel,
   output logic cap_rad,
   output logic cap_ir,
   output logic fus_start,
   output logic fus_single,
   output logic fus_src,
   output logic out_valid,
   input  logic out_ready,
   output logic busy
);

   state_t     state;
   logic [7:0] lat_cnt;
   logic       rad_capd;
   logic       ir_capd;
   logic       gnt_valid;
   logic       gnt_id;
   logic       to_fire;

   ekf_rr_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       ({ir_req, rad_req}),
      .elig      ({~ir_capd, ~rad_capd}),
      .en        (state == S_IDLE),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign busy = (state != S_IDLE) | rad_capd | ir_capd;

`ifdef EKF_SCHED_TIMEOUT_EN
   logic [7:0] to_cnt;

   // idle cycles spent waiting for the missing sensor once the other is captured
   assign to_fire = (state == S_IDLE) && !gnt_valid && (rad_capd ^ ir_capd)
                    && (to_cnt >= 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || gnt_valid || state == S_DONE)
         to_cnt <= '0;
      else if (state == S_IDLE && (rad_capd ^ ir_capd))
         to_cnt <= sat_inc(to_cnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fus_single <= 1'b0;
         fus_src    <= 1'b0;
      end else if (to_fire) begin
         fus_single <= 1'b1;
         fus_src    <= ir_capd;
      end else if (state == S_DONE && out_ready) begin
         fus_single <= 1'b0;
         fus_src    <= 1'b0;
      end
   end
`else
   assign to_fire    = 1'b0;
   assign fus_single = 1'b0;
   assign fus_src    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         lat_cnt   <= '0;
         rad_capd  <= 1'b0;
         ir_capd   <= 1'b0;
         mu_en     <= 1'b0;
         mu_sel    <= 1'b0;
         cap_rad   <= 1'b0;
         cap_ir    <= 1'b0;
         rad_ack   <= 1'b0;
         ir_ack    <= 1'b0;
         fus_start <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         cap_rad   <= 1'b0;
         cap_ir    <= 1'b0;
         rad_ack   <= 1'b0;
         ir_ack    <= 1'b0;
         fus_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt_valid) begin
                  state   <= S_MEAS;
                  mu_en   <= 1'b1;
                  mu_sel  <= gnt_id;
                  lat_cnt <= 8'd1;
               end else if (to_fire) begin
                  state     <= S_FUSE;
                  fus_start <= 1'b1;
                  lat_cnt   <= 8'd1;
               end
            end
            S_MEAS: begin
               if (lat_cnt >= 8'(MU_LAT)) begin
                  state <= S_CAPT;
                  mu_en <= 1'b0;
                  if (mu_sel == SRC_IR) begin
                     cap_ir  <= 1'b1;
                     ir_ack  <= 1'b1;
                     ir_capd <= 1'b1;
                  end else begin
                     cap_rad  <= 1'b1;
                     rad_ack  <= 1'b1;
                     rad_capd <= 1'b1;
                  end
               end else begin
                  lat_cnt <= sat_inc(lat_cnt);
               end
            end
            S_CAPT: begin
               if (rad_capd && ir_capd) begin
                  state     <= S_FUSE;
                  fus_start <= 1'b1;
                  lat_cnt   <= 8'd1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_FUSE: begin
               if (lat_cnt >= 8'(FUS_LAT)) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
               end else begin
                  lat_cnt <= sat_inc(lat_cnt);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  rad_capd  <= 1'b0;
                  ir_capd   <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
